// File: rtl/sr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : sr_fetch_queue
//  Purpose  : Decoupled instruction fetch stage. Issues sequential word
//             fetches over a req/gnt/rvalid memory handshake, buffers the
//             returned words with their PCs in an in-order queue and hands
//             them to decode over valid/ready. A branch redirect flushes the
//             queue and discards responses still in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imReq,
  output logic [31:0] imAddr,
  input  logic        imGnt,
  input  logic        imRvalid,
  input  logic [31:0] imRdata,
  output logic        vld_F,
  output logic [31:0] instr_F,
  output logic [31:0] pc_F,
  input  logic        rdy_D
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_head_pc;
  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;

  logic [CW:0]   w_occupancy;
  logic          w_grant;
  logic          w_pop;
  logic          w_discard;
  logic          w_push;
  logic [31:0]   w_redirect_pc;
  logic          w_unused_bits;

  // Requests plus buffered entries never exceed DEPTH, so a response always
  // finds a free slot; rst_n keeps the request low while reset is held.
  assign w_occupancy   = {1'b0, r_inflight} + {1'b0, r_count};
  assign imReq         = rst_n & ~redirect & (w_occupancy < C_DEPTH);
  assign imAddr        = {2'b00, r_fetch_pc[31:2]};
  assign w_grant       = imReq & imGnt;
  assign vld_F         = (r_count != '0);
  assign instr_F       = r_mem[r_rd_ptr];
  assign pc_F          = r_head_pc;
  assign w_pop         = vld_F & rdy_D;
  assign w_discard     = imRvalid & (r_drop != '0);
  assign w_push        = imRvalid & ~w_discard;
  assign w_redirect_pc = {redirectPc[31:2], 2'b00};
  assign w_unused_bits = &{1'b0, redirectPc[1:0]};

  // Fetch and head PCs: both jump on redirect, otherwise advance by a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_head_pc  <= w_redirect_pc;
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_pop)   r_head_pc  <= r_head_pc + 32'd4;
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Outstanding request tracking; on redirect every still-pending response
  // becomes stale, including any left over from an earlier redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (redirect) begin
      r_inflight <= r_inflight - CW'(imRvalid);
      r_drop     <= r_inflight - CW'(imRvalid);
    end else begin
      r_inflight <= r_inflight + CW'(w_grant) - CW'(imRvalid);
      if (w_discard) r_drop <= r_drop - 1'b1;
    end
  end

  // Instruction storage, written at the write pointer by live responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!redirect && w_push) begin
      r_mem[r_wr_ptr] <= imRdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_fetch_queue
//  Purpose  : Randomized self-checking bench for sr_fetch_queue. The bench
//             plays the instruction memory and keeps a transaction-level
//             model: a list of outstanding requests (tagged stale on
//             redirect) and a list of expected {pc, instr} queue entries.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imReq;
  logic [31:0] imAddr;
  logic        imGnt = 1'b0;
  logic        imRvalid = 1'b0;
  logic [31:0] imRdata = '0;
  logic        vld_F;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic        rdy_D = 1'b0;

  sr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirectPc(redirectPc),
    .imReq(imReq), .imAddr(imAddr), .imGnt(imGnt), .imRvalid(imRvalid),
    .imRdata(imRdata), .vld_F(vld_F), .instr_F(instr_F), .pc_F(pc_F),
    .rdy_D(rdy_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          ready;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] qpc[$];
  logic [31:0] qins[$];
  logic [31:0] m_pc;
  int          cyc;
  int          n_total;
  int          n_bad;

  // Memory contents: a scrambled function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    qpc.delete();
    qins.delete();
    m_pc = RESET_PC;
  endtask

  task automatic check_reset_outputs();
    check("rst_imReq", {31'b0, imReq}, 32'd0);
    check("rst_imAddr", imAddr, RESET_PC >> 2);
    check("rst_vld_F", {31'b0, vld_F}, 32'd0);
    check("rst_instr_F", instr_F, 32'd0);
    check("rst_pc_F", pc_F, RESET_PC);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then
  // advance the model by the same cycle's events.
  task automatic step(input bit gnt, input int lat, input bit do_redir,
                      input logic [31:0] rpc, input bit rdy);
    bit          rv;
    bit          exp_req;
    bit          exp_vld;
    req_t        e;
    logic [31:0] tmp;
    @(negedge clk);
    rv         = (pend.size() > 0) && (pend[0].ready <= cyc);
    redirect   = do_redir;
    redirectPc = rpc;
    rdy_D      = rdy;
    imGnt      = gnt;
    imRvalid   = rv;
    imRdata    = rv ? mem_word(pend[0].pc >> 2) : $urandom;
    #1;
    exp_req = !do_redir && ((pend.size() + qpc.size()) < DEPTH);
    exp_vld = (qpc.size() != 0);
    check("imReq", {31'b0, imReq}, {31'b0, exp_req});
    if (exp_req) check("imAddr", imAddr, m_pc >> 2);
    check("vld_F", {31'b0, vld_F}, {31'b0, exp_vld});
    if (exp_vld) begin
      check("pc_F", pc_F, qpc[0]);
      check("instr_F", instr_F, qins[0]);
    end
    if (do_redir) begin
      if (rv) e = pend.pop_front();
      foreach (pend[i]) pend[i].stale = 1'b1;
      qpc.delete();
      qins.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_vld && rdy) begin
        tmp = qpc.pop_front();
        tmp = qins.pop_front();
      end
      if (rv) begin
        e = pend.pop_front();
        if (!e.stale) begin
          qpc.push_back(e.pc);
          qins.push_back(mem_word(e.pc >> 2));
        end
      end
      if (exp_req && gnt) begin
        pend.push_back('{pc: m_pc, ready: cyc + lat, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom % 5)
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0200;
      2:       return 32'hFFFF_FFF8 | ($urandom % 4);
      default: return $urandom;
    endcase
  endfunction

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(4, 1)),
           ($urandom % 32) == 0, pick_pc(), ($urandom % 4) != 0);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    model_reset();

    // Reset values while rst_n is held low.
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: always-grant 1-cycle memory, decode always ready.
    for (int i = 0; i < 30; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1);

    // Back-pressure: decode stalls, then drains.
    for (int i = 0; i < 12; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1);

    // Redirect with rvalid and pop in the same cycle.
    step(1'b1, 1, 1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1);

    // Slow memory: redirect with requests in flight, then redirect again.
    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, 32'h0, 1'b1);
    step(1'b1, 3, 1'b1, 32'h0000_0100, 1'b1);
    step(1'b1, 3, 1'b0, 32'h0, 1'b1);
    step(1'b1, 3, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 3, 1'b0, 32'h0, 1'b1);

    // Address wrap-around.
    step(1'b1, 1, 1'b1, 32'hFFFF_FFFA, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1);

    random_run(3000);

    // Reset in the middle of traffic.
    @(negedge clk);
    rst_n    = 1'b0;
    imRvalid = 1'b0;
    redirect = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    random_run(2000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
